// File: rtl/gpmc_sync_target.sv
// GPMC synchronous muxed-bus responder on CS1: decodes address/data phases on gpmc_clk
// into local register-bus write/read strobes and returns read data onto the AD bus.
module gpmc_sync_target #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  gpmc_clk,
  input  logic                  reset,
  input  logic [15:0]           gpmc_ad_in,
  output logic [15:0]           gpmc_ad_out,
  output logic                  gpmc_ad_oe,
  input  logic                  gpmc_advn,
  input  logic                  gpmc_csn1,
  input  logic                  gpmc_wein,
  input  logic                  gpmc_oen,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [15:0]           bus_wr_data,
  output logic                  bus_wr_en,
  output logic                  bus_rd_en,
  input  logic [15:0]           bus_rd_data
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_RD_WAIT,
    ST_RD_DATA
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0]         wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [DW-1:0]         ad_out_q, ad_out_d;

  always_ff @(posedge gpmc_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      lat_q      <= '0;
      bus_addr_q <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      ad_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      lat_q      <= lat_d;
      bus_addr_q <= bus_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      ad_out_q   <= ad_out_d;
    end
  end

  // CS high dominates; an address phase restarts the transaction from any state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    lat_d      = lat_q;
    bus_addr_d = bus_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    ad_out_d   = ad_out_q;
    if (gpmc_csn1) begin
      state_d = ST_IDLE;
    end else if (!gpmc_advn) begin
      addr_d  = ADDR_WIDTH'(gpmc_ad_in);
      state_d = ST_DATA;
    end else begin
      case (state_q)
        ST_DATA: begin
          bus_addr_d = addr_q;
          if (!gpmc_wein) begin
            wr_en_d   = 1'b1;
            wr_data_d = gpmc_ad_in;
            addr_d    = addr_q + ADDR_WIDTH'(1);
          end else begin
            rd_en_d = 1'b1;
            lat_d   = CW'(1);
            state_d = ST_RD_WAIT;
          end
        end
        // lat_q counts edges since the one that raised bus_rd_en
        ST_RD_WAIT: begin
          if (lat_q == CW'(RD_LATENCY)) begin
            ad_out_d = bus_rd_data;
            state_d  = ST_RD_DATA;
          end else begin
            lat_d = lat_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign gpmc_ad_out = ad_out_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = wr_data_q;
  assign bus_wr_en   = wr_en_q;
  assign bus_rd_en   = rd_en_q;
  // Pad enable follows OE_n/CS_n without waiting for a clock edge.
  assign gpmc_ad_oe  = (state_q == ST_RD_DATA) & ~gpmc_csn1 & ~gpmc_oen;

endmodule

// File: tb/tb_gpmc_sync_target.sv
// Bench for gpmc_sync_target: drives GPMC transactions on a gated clock into two instances
// (read latency 1 and 2) and checks strobes and read return against a transaction-level model.
module tb_gpmc_sync_target;

  logic        gpmc_clk, reset;
  logic        csn, advn, wein, oen;
  logic [15:0] ad_in;
  logic [15:0] rd_data [2];
  logic [15:0] ad_out [2];
  logic        oe [2];
  logic [15:0] bus_addr [2];
  logic [15:0] wr_data [2];
  logic        wr_en [2];
  logic        rd_en [2];

  gpmc_sync_target #(.ADDR_WIDTH(16), .RD_LATENCY(1)) u_l1 (
    .gpmc_clk(gpmc_clk), .reset(reset), .gpmc_ad_in(ad_in), .gpmc_ad_out(ad_out[0]),
    .gpmc_ad_oe(oe[0]), .gpmc_advn(advn), .gpmc_csn1(csn), .gpmc_wein(wein), .gpmc_oen(oen),
    .bus_addr(bus_addr[0]), .bus_wr_data(wr_data[0]), .bus_wr_en(wr_en[0]),
    .bus_rd_en(rd_en[0]), .bus_rd_data(rd_data[0]));

  gpmc_sync_target #(.ADDR_WIDTH(16), .RD_LATENCY(2)) u_l2 (
    .gpmc_clk(gpmc_clk), .reset(reset), .gpmc_ad_in(ad_in), .gpmc_ad_out(ad_out[1]),
    .gpmc_ad_oe(oe[1]), .gpmc_advn(advn), .gpmc_csn1(csn), .gpmc_wein(wein), .gpmc_oen(oen),
    .bus_addr(bus_addr[1]), .bus_wr_data(wr_data[1]), .bus_wr_en(wr_en[1]),
    .bus_rd_en(rd_en[1]), .bus_rd_data(rd_data[1]));

  int checks = 0;
  int failures = 0;

  // Observed strobe history per instance
  int          wr_cnt [2];
  int          rd_cnt [2];
  logic [15:0] last_wa [2];
  logic [15:0] last_wd [2];
  logic [15:0] last_ra [2];

  // Slave model: read data is valid only in the cycle it is due, junk otherwise
  int          age [2];
  logic [15:0] rd_val;

  // Transaction-level expectations
  bit          use_model;
  logic [31:0] ew0[$], ew1[$];
  logic [15:0] er0[$], er1[$];

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%h expected=%h", name, k, got, exp);
    end
  endtask

  task automatic model_wr(input int k, input logic [31:0] act);
    logic [31:0] e;
    bit found;
    found = 0;
    e = '0;
    if (k == 0 && ew0.size() > 0) begin e = ew0.pop_front(); found = 1; end
    if (k == 1 && ew1.size() > 0) begin e = ew1.pop_front(); found = 1; end
    if (!found) chk("spurious_wr", k, act, 32'hffff_ffff);
    else        chk("wr_strobe", k, act, e);
  endtask

  task automatic model_rd(input int k, input logic [15:0] act);
    logic [15:0] e;
    bit found;
    found = 0;
    e = '0;
    if (k == 0 && er0.size() > 0) begin e = er0.pop_front(); found = 1; end
    if (k == 1 && er1.size() > 0) begin e = er1.pop_front(); found = 1; end
    if (!found) chk("spurious_rd", k, {16'h0, act}, 32'hffff_ffff);
    else        chk("rd_strobe", k, {16'h0, act}, {16'h0, e});
  endtask

  // One gated-clock pulse; outputs sampled 2 time units after the rising edge
  task automatic tick();
    gpmc_clk = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin
      if (wr_en[k]) begin
        wr_cnt[k]++;
        last_wa[k] = bus_addr[k];
        last_wd[k] = wr_data[k];
        if (use_model) model_wr(k, {bus_addr[k], wr_data[k]});
      end
      if (rd_en[k]) begin
        rd_cnt[k]++;
        last_ra[k] = bus_addr[k];
        if (use_model) model_rd(k, bus_addr[k]);
        age[k] = 1;
      end else if (age[k] > 0) begin
        age[k]++;
      end
      rd_data[k] = (age[k] == k + 1) ? rd_val : ~rd_val;
      if (!wein) chk("oe_with_wein_low", k, {31'h0, oe[k]}, 32'h0);
    end
    #3 gpmc_clk = 1'b0;
    #5;
  endtask

  task automatic wr_txn(input logic [15:0] addr, input int len, input logic [15:0] d0,
                        input logic [15:0] step, input bit keep_cs, input int post);
    logic [15:0] d;
    csn = 1'b0; advn = 1'b0; wein = 1'b0; oen = 1'b1; ad_in = addr;
    tick();
    advn = 1'b1;
    for (int i = 0; i < len; i++) begin
      d = 16'(d0 + 16'(i) * step);
      ad_in = d;
      if (use_model) begin
        ew0.push_back({16'(addr + 16'(i)), d});
        ew1.push_back({16'(addr + 16'(i)), d});
      end
      tick();
    end
    if (!keep_cs) begin
      csn = 1'b1; wein = 1'b1; ad_in = 16'h0;
      repeat (post) tick();
    end
  endtask

  task automatic rd_txn(input logic [15:0] addr, input logic [15:0] data,
                        input bit keep_cs, input int post);
    rd_val = data;
    for (int k = 0; k < 2; k++) rd_data[k] = ~rd_val;
    csn = 1'b0; advn = 1'b0; wein = 1'b1; oen = 1'b1; ad_in = addr;
    tick();
    advn = 1'b1; oen = 1'b0; ad_in = ~addr;
    if (use_model) begin er0.push_back(addr); er1.push_back(addr); end
    tick();
    tick();
    chk("oe_lat1_clk2", 0, {31'h0, oe[0]}, 32'h1);
    chk("oe_lat2_clk2", 1, {31'h0, oe[1]}, 32'h0);
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("oe_by_clk3", k, {31'h0, oe[k]}, 32'h1);
      chk("rd_data_by_clk3", k, {16'h0, ad_out[k]}, {16'h0, data});
    end
    tick();
    oen = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) chk("oe_release", k, {31'h0, oe[k]}, 32'h0);
    if (!keep_cs) begin
      csn = 1'b1;
      repeat (post) tick();
    end
  endtask

  task automatic model_drained();
    chk("missing_wr", 0, 32'(ew0.size()), 32'h0);
    chk("missing_wr", 1, 32'(ew1.size()), 32'h0);
    chk("missing_rd", 0, 32'(er0.size()), 32'h0);
    chk("missing_rd", 1, 32'(er1.size()), 32'h0);
    ew0.delete(); ew1.delete(); er0.delete(); er1.delete();
  endtask

  task automatic chk_all_zero(input string name);
    for (int k = 0; k < 2; k++) begin
      chk({name, "_ad_out"}, k, {16'h0, ad_out[k]}, 32'h0);
      chk({name, "_oe"}, k, {31'h0, oe[k]}, 32'h0);
      chk({name, "_addr"}, k, {16'h0, bus_addr[k]}, 32'h0);
      chk({name, "_wdata"}, k, {16'h0, wr_data[k]}, 32'h0);
      chk({name, "_wr_en"}, k, {31'h0, wr_en[k]}, 32'h0);
      chk({name, "_rd_en"}, k, {31'h0, rd_en[k]}, 32'h0);
    end
  endtask

  typedef struct {
    bit          is_rd;
    logic [15:0] addr;
    int          len;
    logic [15:0] d0;
    logic [15:0] step;
    bit          keep_cs;
    int          post;
    int          exp_cnt;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int w0, r0;
    gpmc_clk = 1'b0; reset = 1'b1;
    csn = 1'b1; advn = 1'b1; wein = 1'b1; oen = 1'b1; ad_in = 16'h0;
    rd_val = 16'h0; use_model = 0;
    for (int k = 0; k < 2; k++) begin
      rd_data[k] = 16'hffff; age[k] = 0; wr_cnt[k] = 0; rd_cnt[k] = 0;
      last_wa[k] = '0; last_wd[k] = '0; last_ra[k] = '0;
    end
    #3;
    chk_all_zero("reset");
    #2 reset = 1'b0;
    #5;

    //            rd addr      len d0        step      keep post cnt exp_addr  exp_data
    vecs[0]  = '{0, 16'h1000, 1, 16'hABCD, 16'h0000, 0, 1, 1, 16'h1000, 16'hABCD};
    vecs[1]  = '{0, 16'h1000, 1, 16'h0001, 16'h0000, 0, 0, 1, 16'h1000, 16'h0001};
    vecs[2]  = '{0, 16'h1000, 1, 16'h0002, 16'h0000, 0, 2, 1, 16'h1000, 16'h0002};
    vecs[3]  = '{0, 16'h1000, 1, 16'h0003, 16'h0000, 0, 0, 1, 16'h1000, 16'h0003};
    vecs[4]  = '{0, 16'h1000, 1, 16'h0004, 16'h0000, 0, 2, 1, 16'h1000, 16'h0004};
    vecs[5]  = '{0, 16'h0010, 3, 16'h1111, 16'h1111, 0, 1, 3, 16'h0012, 16'h3333};
    vecs[6]  = '{0, 16'hFFFF, 2, 16'h0001, 16'h0001, 0, 1, 2, 16'h0000, 16'h0002};
    vecs[7]  = '{0, 16'h0300, 1, 16'h0777, 16'h0000, 1, 0, 1, 16'h0300, 16'h0777};
    vecs[8]  = '{0, 16'h0040, 1, 16'h0888, 16'h0000, 0, 1, 1, 16'h0040, 16'h0888};
    vecs[9]  = '{1, 16'h0020, 1, 16'h1234, 16'h0000, 0, 1, 1, 16'h0020, 16'h1234};
    vecs[10] = '{1, 16'h0021, 1, 16'hBEEF, 16'h0000, 1, 0, 1, 16'h0021, 16'hBEEF};
    vecs[11] = '{0, 16'h0050, 2, 16'h0A0A, 16'h0101, 0, 1, 2, 16'h0051, 16'h0B0B};

    for (int v = 0; v < 12; v++) begin
      w0 = wr_cnt[0]; r0 = rd_cnt[0];
      if (vecs[v].is_rd) rd_txn(vecs[v].addr, vecs[v].d0, vecs[v].keep_cs, vecs[v].post);
      else wr_txn(vecs[v].addr, vecs[v].len, vecs[v].d0, vecs[v].step, vecs[v].keep_cs, vecs[v].post);
      for (int k = 0; k < 2; k++) begin
        if (vecs[v].is_rd) begin
          chk($sformatf("vec%0d_rd_cnt", v), k, 32'(rd_cnt[k] - r0), 32'(vecs[v].exp_cnt));
          chk($sformatf("vec%0d_wr_cnt", v), k, 32'(wr_cnt[k] - w0), 32'h0);
          chk($sformatf("vec%0d_rd_addr", v), k, {16'h0, last_ra[k]}, {16'h0, vecs[v].exp_addr});
          chk($sformatf("vec%0d_rd_data", v), k, {16'h0, ad_out[k]}, {16'h0, vecs[v].exp_data});
        end else begin
          chk($sformatf("vec%0d_wr_cnt", v), k, 32'(wr_cnt[k] - w0), 32'(vecs[v].exp_cnt));
          chk($sformatf("vec%0d_rd_cnt", v), k, 32'(rd_cnt[k] - r0), 32'h0);
          chk($sformatf("vec%0d_wr_addr", v), k, {16'h0, last_wa[k]}, {16'h0, vecs[v].exp_addr});
          chk($sformatf("vec%0d_wr_data", v), k, {16'h0, last_wd[k]}, {16'h0, vecs[v].exp_data});
        end
      end
    end

    // Reset while the read is waiting for its data
    csn = 1'b1;
    tick();
    rd_val = 16'hC0DE;
    csn = 1'b0; advn = 1'b0; wein = 1'b1; oen = 1'b1; ad_in = 16'h0070;
    tick();
    advn = 1'b1; oen = 1'b0;
    tick();
    chk("rd_en_before_reset", 0, {31'h0, rd_en[0]}, 32'h1);
    #1 reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    #2 reset = 1'b0;
    age[0] = 0; age[1] = 0;
    w0 = wr_cnt[0]; r0 = rd_cnt[0];
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      chk("post_reset_oe", k, {31'h0, oe[k]}, 32'h0);
      chk("post_reset_rd_cnt", k, 32'(rd_cnt[k] - r0), 32'h0);
      chk("post_reset_wr_cnt", k, 32'(wr_cnt[k] - w0), 32'h0);
    end
    oen = 1'b1; csn = 1'b1;
    tick();
    wr_txn(16'h0001, 1, 16'h5A5A, 16'h0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      chk("after_reset_wr_cnt", k, 32'(wr_cnt[k] - w0), 32'h1);
      chk("after_reset_wr_addr", k, {16'h0, last_wa[k]}, 32'h0001);
      chk("after_reset_wr_data", k, {16'h0, last_wd[k]}, 32'h5A5A);
    end

    // Randomized transactions against the transaction-level model
    use_model = 1;
    for (int t = 0; t < 40; t++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
      if ($urandom_range(0, 2) == 0)
        rd_txn(a, 16'($urandom), bit'($urandom_range(0, 1)), $urandom_range(0, 2));
      else
        wr_txn(a, $urandom_range(1, 4), 16'($urandom), 16'($urandom),
               bit'($urandom_range(0, 1)), $urandom_range(0, 2));
      if (!csn) begin
        // Leave the bus cleanly before judging completeness
        csn = 1'b1; wein = 1'b1; oen = 1'b1;
      end
      tick();
      model_drained();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
